mnist_frame_feeder: RTL and testbench
=====================================

Name: mnist_frame_feeder

Overview:
- Upstream stage of the MNIST inference pipeline. Sits between the host byte interface (UART/DMA shim) and the network top.
- Accepts one 28x28 frame of 8-bit pixels over a valid/ready handshake and buffers the whole frame.
- Converts each pixel to the network fixed-point format and streams the frame as one gap-free burst on the network's input_valid/input_val.
- Then waits for the network's classification result, registers the digit, and reopens for the next frame.

Parameters:
- NUM_PIXELS, 784, pixels per frame; must equal the network's first-layer input count.
- DATAWIDTH, 16, width of the fixed-point pixel sent to the network.
- WEIGHTINTWIDTH, 4, integer bits of the fixed-point format; fraction bits = DATAWIDTH-WEIGHTINTWIDTH, which must be >= 8.
- RESULT_TIMEOUT, 4096, cycles to wait in WAIT_RES before abandoning the frame.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- s_valid  in  1  host pixel valid.
- s_ready  out  1  feeder can accept a pixel.
- s_data  in  8  unsigned pixel, 0..255.
- px_valid  out  1  drives the network input_valid.
- px_data  out  DATAWIDTH  drives the network input_val.
- res_in  in  32  network class index (the maxfinder output).
- res_valid  in  1  network result valid.
- digit  out  4  last classified digit.
- digit_valid  out  1  one-cycle pulse when digit updates.
- timeout_err  out  1  one-cycle pulse when the result wait expires.
- busy  out  1  high in STREAM and WAIT_RES.

Behaviour:
- Reset (rst=0 at an edge): state=LOAD, wr_addr=0, rd_addr=0, timer=0. Outputs: s_ready=0 during reset then 1 in LOAD; px_valid=0, px_data=0, digit=0, digit_valid=0, timeout_err=0, busy=0. Reset mid-operation aborts any partial load, stream or wait; buffer contents are don't-care.
- States: LOAD, STREAM, WAIT_RES.
- LOAD:
  - s_ready=1 (combinational from state).
  - On s_valid&&s_ready: write s_data to buf[wr_addr] and increment wr_addr.
  - Host stalls (s_valid low) are allowed; wr_addr holds.
  - On acceptance with wr_addr==NUM_PIXELS-1: wr_addr<=0, next state STREAM.
- STREAM:
  - s_ready=0, busy=1.
  - The frame buffer has a registered read port, so there is one cycle of read latency.
  - If the last pixel is accepted at edge T: state=STREAM from T+1, read of addr 0 issued at T+1, px_valid=1 with pixel 0 from T+2.
  - px_valid stays high for exactly NUM_PIXELS consecutive cycles, pixel k at T+2+k, with no gaps.
  - After the last pixel, px_valid=0 and state=WAIT_RES.
- Pixel conversion: px_data = zero-extend(s_data) << (DATAWIDTH-WEIGHTINTWIDTH-8), i.e. value p/256, always non-negative. The conversion is applied on the buffer read path. When px_valid=0, px_data=0.
- WAIT_RES:
  - s_ready=0, busy=1. timer increments each cycle starting from 0.
  - On res_valid: digit<=res_in[3:0], digit_valid pulses for 1 cycle, timer<=0, next state LOAD.
  - If timer reaches RESULT_TIMEOUT-1 with no res_valid: timeout_err pulses for 1 cycle, digit unchanged, next state LOAD.
  - If res_valid arrives on the same cycle as expiry, the result wins: no timeout_err.
- res_valid outside WAIT_RES is ignored; no digit_valid is generated.
- res_in values above 9 are still latched as res_in[3:0]; range checking is out of scope.
- The host may present s_valid during STREAM/WAIT_RES; nothing is accepted until the next LOAD.
- Throughput: at best one frame per NUM_PIXELS load cycles + NUM_PIXELS+2 stream cycles + network latency.

Decomposition:
- Shared package (mnist_pkg): state encoding constants (LOAD/STREAM/WAIT_RES), the NUM_PIXELS default, and the fixed-point format constants DATAWIDTH and WEIGHTINTWIDTH, so the feeder and the layers agree.
- One sub-module, frame_buffer: single-clock simple dual-port RAM, NUM_PIXELS x 8, registered read, inferable as BRAM.
- FSM, counters and conversion live in mnist_frame_feeder.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> s_ready=1, busy=0, px_valid=0, digit=0, no pulses.
- Full frame, pixel k = k mod 256, no stalls:
  - px_valid high for exactly 784 consecutive cycles, starting 2 cycles after the last accept.
  - Pixel 1 -> px_data=0x0010; pixel 255 -> 0x0FF0; s_ready=0 throughout.
- Host stalls: s_valid toggles 1-0-1 randomly while loading 784 pixels -> the streamed sequence exactly matches the input order, with a single gap-free burst.
- Result:
  - In WAIT_RES, drive res_in=7 with res_valid for 1 cycle -> digit=7, digit_valid 1 cycle, s_ready=1 next cycle.
  - res_valid pulsed during LOAD -> ignored.
- Timeout with RESULT_TIMEOUT=16:
  - No res_valid -> timeout_err pulses exactly 16 cycles after WAIT_RES entry; digit unchanged; back to LOAD.
  - res_valid on the expiry cycle -> digit_valid only, no timeout_err.
- Reset mid-stream: rst=0 at pixel 400 -> px_valid=0 next cycle, state LOAD.
  - A following full frame streams correctly from pixel 0.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants for the MNIST pipeline: frame size, fixed-point format, feeder states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mnist_pkg;

    // One 28x28 frame; must match the first layer's input count.
    localparam int MNIST_NUM_PIXELS     = 784;

    // Fixed-point format shared by the feeder and the layers.
    localparam int MNIST_DATAWIDTH      = 16;
    localparam int MNIST_WEIGHTINTWIDTH = 4;

    // Cycles the feeder waits for a classification before giving up.
    localparam int MNIST_RESULT_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RES = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/frame_buffer.sv
// Single-clock simple dual-port pixel RAM, one write port and one read port.
// Latency: one cycle from rd_en/rd_addr to rd_data.
// Backpressure: none; the caller owns all sequencing.
module frame_buffer #(
    parameter int DEPTH = 784,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;

    // Write port plus registered read port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mnist_frame_feeder.sv
// Buffers one frame of 8-bit pixels, streams it as fixed-point to the network, then latches the digit.
// Latency: first pixel out 2 cycles after the last pixel is accepted; burst is NUM_PIXELS cycles gap-free.
// Backpressure: s_ready is high only in LOAD; the network side has no backpressure (the burst never stalls).
module mnist_frame_feeder
    import mnist_pkg::*;
#(
    parameter int NUM_PIXELS     = MNIST_NUM_PIXELS,
    parameter int DATAWIDTH      = MNIST_DATAWIDTH,
    parameter int WEIGHTINTWIDTH = MNIST_WEIGHTINTWIDTH,
    parameter int RESULT_TIMEOUT = MNIST_RESULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    output logic                 px_valid,
    output logic [DATAWIDTH-1:0] px_data,
    input  logic [31:0]          res_in,
    input  logic                 res_valid,
    output logic [3:0]           digit,
    output logic                 digit_valid,
    output logic                 timeout_err,
    output logic                 busy
);

    // Address counters must reach NUM_PIXELS so the read side can mark "all issued".
    localparam int AW         = $clog2(NUM_PIXELS + 1);
    localparam int TW         = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;
    // Pixel p becomes p/256 in the network format: shift the byte up to the top of the fraction.
    localparam int FRAC_SHIFT = DATAWIDTH - WEIGHTINTWIDTH - 8;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_PIXELS - 1);
    localparam logic [AW-1:0] END_ADDR  = AW'(NUM_PIXELS);
    localparam logic [TW-1:0] LAST_TICK = TW'(RESULT_TIMEOUT - 1);

    feeder_state_e state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          px_valid_q, px_valid_d;
    logic [3:0]    digit_q, digit_d;
    logic          digit_valid_q, digit_valid_d;
    logic          timeout_err_q, timeout_err_d;

    logic                 wr_en;
    logic                 rd_en;
    logic [7:0]           rd_data;
    logic [DATAWIDTH-1:0] px_conv;
    logic                 accept;
    logic                 unused_res;

    // Only the low nibble of the class index is meaningful to this block.
    assign unused_res = ^res_in[31:4];

    // Held low while reset is asserted so the host never sees a handshake that gets dropped.
    assign s_ready = (state_q == ST_LOAD) && rst;
    assign busy    = (state_q == ST_STREAM) || (state_q == ST_WAIT_RES);
    assign accept  = s_valid && s_ready;

    frame_buffer #(
        .DEPTH (NUM_PIXELS),
        .AW    (AW)
    ) u_frame_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_q),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (rd_data)
    );

    // Conversion sits on the read path; the bus is forced to zero outside the burst.
    assign px_conv     = DATAWIDTH'(rd_data) << FRAC_SHIFT;
    assign px_valid    = px_valid_q;
    assign px_data     = px_valid_q ? px_conv : '0;
    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign timeout_err = timeout_err_q;

    // Next-state logic: load counter, burst read sequencer, result wait with timeout.
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        timer_d       = timer_q;
        px_valid_d    = 1'b0;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        timeout_err_d = 1'b0;
        wr_en         = 1'b0;
        rd_en         = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d = '0;
                        state_d   = ST_STREAM;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end

            ST_STREAM: begin
                // One read per cycle; px_valid trails the read by the RAM latency.
                if (rd_addr_q != END_ADDR) begin
                    rd_en      = 1'b1;
                    px_valid_d = 1'b1;
                    rd_addr_d  = rd_addr_q + AW'(1);
                end else begin
                    rd_addr_d = '0;
                    timer_d   = '0;
                    state_d   = ST_WAIT_RES;
                end
            end

            ST_WAIT_RES: begin
                // A result on the expiry cycle takes priority over the timeout.
                if (res_valid) begin
                    digit_d       = res_in[3:0];
                    digit_valid_d = 1'b1;
                    timer_d       = '0;
                    state_d       = ST_LOAD;
                end else if (timer_q == LAST_TICK) begin
                    timeout_err_d = 1'b1;
                    timer_d       = '0;
                    state_d       = ST_LOAD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_LOAD;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            timer_q       <= '0;
            px_valid_q    <= 1'b0;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            timer_q       <= timer_d;
            px_valid_q    <= px_valid_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_mnist_frame_feeder.sv
// Directed bench for mnist_frame_feeder: load, burst, result, timeout and reset scenarios.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: host stalls are randomised during selected frame loads.
module tb_mnist_frame_feeder;

    localparam int NP = 784;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        px_valid;
    logic [15:0] px_data;
    logic [31:0] res_in = 32'd0;
    logic        res_valid = 1'b0;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        timeout_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pix [NP];

    always #5 clk = ~clk;

    mnist_frame_feeder #(
        .NUM_PIXELS     (NP),
        .DATAWIDTH      (16),
        .WEIGHTINTWIDTH (4),
        .RESULT_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .px_valid    (px_valid),
        .px_data     (px_data),
        .res_in      (res_in),
        .res_valid   (res_valid),
        .digit       (digit),
        .digit_valid (digit_valid),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present the frame in pix[], optionally stalling; returns on the edge that presents the last pixel.
    task automatic load_frame(input int stall_pct);
        int k = 0;
        int guard = 0;
        int sready_bad = 0;
        while (k < NP && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (s_ready !== 1'b1) sready_bad++;
            if ($urandom_range(99) < stall_pct) begin
                s_valid = 1'b0;
                s_data  = 8'h55;
            end else begin
                s_valid = 1'b1;
                s_data  = pix[k];
                k++;
            end
        end
        chk("load_sready", sready_bad, 0);
        chk("load_count", k, NP);
    endtask

    // Walk the burst cycle by cycle; returns on the first WAIT_RES cycle, or asserts reset at abort_off.
    task automatic stream_check(input int abort_off, input bit spot);
        int vbad = 0;
        int dbad = 0;
        int rbad = 0;
        logic        exp_v;
        logic [15:0] exp_d;
        for (int off = 1; off <= NP + 2; off++) begin
            @(negedge clk);
            exp_v = (off >= 2) && (off <= NP + 1);
            exp_d = 16'd0;
            if (exp_v) exp_d = 16'(pix[off-2]) * 16'd16;
            if (px_valid !== exp_v) vbad++;
            if (px_data !== exp_d) dbad++;
            if (s_ready !== 1'b0 || busy !== 1'b1) rbad++;
            if (spot && off == 3)   chk("px_pixel1", {16'd0, px_data}, 32'h0010);
            if (spot && off == 257) chk("px_pixel255", {16'd0, px_data}, 32'h0FF0);
            if (off == abort_off) begin
                rst     = 1'b0;
                s_valid = 1'b0;
                break;
            end
            // Host keeps offering a pixel during the burst; none of it may be taken.
            s_valid = (off < NP + 2);
            s_data  = 8'hAA;
        end
        chk("stream_valid_mism", vbad, 0);
        chk("stream_data_mism", dbad, 0);
        chk("stream_ready_busy_mism", rbad, 0);
    endtask

    initial begin
        int tbad;

        // Reset held for three cycles.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sready_low", s_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_px_valid", px_valid, 0);
        chk("rst_px_data", px_data, 0);
        chk("rst_digit", digit, 0);
        chk("rst_digit_valid", digit_valid, 0);
        chk("rst_timeout", timeout_err, 0);

        // Frame 1: k mod 256, no stalls, result 7.
        for (int k = 0; k < NP; k++) pix[k] = 8'(k % 256);
        load_frame(0);
        stream_check(0, 1'b1);
        res_valid = 1'b1;
        res_in    = 32'd7;
        @(negedge clk);
        res_valid = 1'b0;
        chk("f1_digit", digit, 7);
        chk("f1_digit_valid", digit_valid, 1);
        chk("f1_sready_after", s_ready, 1);
        chk("f1_busy_after", busy, 0);
        // A result while loading must be ignored.
        res_valid = 1'b1;
        res_in    = 32'd5;
        @(negedge clk);
        res_valid = 1'b0;
        chk("f1_digit_valid_one_cycle", digit_valid, 0);
        @(negedge clk);
        chk("load_res_ignored_pulse", digit_valid, 0);
        chk("load_res_ignored_digit", digit, 7);

        // Frame 2: scrambled pattern with host stalls, then timeout.
        for (int k = 0; k < NP; k++) pix[k] = 8'((k * 37 + 11) % 256);
        load_frame(40);
        stream_check(0, 1'b0);
        tbad = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (timeout_err !== 1'b0 || busy !== 1'b1) tbad++;
        end
        chk("to_early", tbad, 0);
        @(negedge clk);
        chk("to_pulse", timeout_err, 1);
        chk("to_no_digit_valid", digit_valid, 0);
        chk("to_digit_kept", digit, 7);
        chk("to_back_to_load", s_ready, 1);
        @(negedge clk);
        chk("to_pulse_one_cycle", timeout_err, 0);

        // Frame 3: result arrives on the expiry cycle; value above 9 keeps its low nibble.
        for (int k = 0; k < NP; k++) pix[k] = 8'(k % 256);
        load_frame(0);
        stream_check(0, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 15) begin
                res_valid = 1'b1;
                res_in    = 32'h0000_002C;
            end
        end
        @(negedge clk);
        res_valid = 1'b0;
        chk("exp_digit_valid", digit_valid, 1);
        chk("exp_no_timeout", timeout_err, 0);
        chk("exp_digit", digit, 4'hC);

        // Frame 4: reset asserted while pixel 400 is on the bus.
        load_frame(0);
        stream_check(402, 1'b0);
        @(negedge clk);
        chk("midrst_px_valid", px_valid, 0);
        chk("midrst_px_data", px_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_digit", digit, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sready", s_ready, 1);

        // Frame 5: fresh frame after the abort, with stalls, result 9.
        for (int k = 0; k < NP; k++) pix[k] = 8'(255 - (k % 256));
        load_frame(20);
        stream_check(0, 1'b0);
        res_valid = 1'b1;
        res_in    = 32'd9;
        @(negedge clk);
        res_valid = 1'b0;
        chk("f5_digit", digit, 9);
        chk("f5_digit_valid", digit_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
